// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller: MG->MY->SG->SY with a BCD countdown of the remaining seconds.
// Optional emergency flash mode (state EM) is built only when TRAFFIC_EMERGENCY_EN is defined.
module traffic_phase_ctrl #(
  parameter int unsigned GREEN_MAIN = 40,
  parameter int unsigned GREEN_SIDE = 20,
  parameter int unsigned YELLOW     = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       COU_CLK,
  input  logic       SH_CLK,
  input  logic       EMERG,
  output logic [2:0] MAIN_LIGHT,
  output logic [2:0] SIDE_LIGHT,
  output logic [3:0] COUNT_TENS,
  output logic [3:0] COUNT_ONES,
  output logic       SEC_TICK
);

  localparam logic [3:0] GM_TENS = 4'(GREEN_MAIN / 10);
  localparam logic [3:0] GM_ONES = 4'(GREEN_MAIN % 10);
  localparam logic [3:0] GS_TENS = 4'(GREEN_SIDE / 10);
  localparam logic [3:0] GS_ONES = 4'(GREEN_SIDE % 10);
  localparam logic [3:0] YL_TENS = 4'(YELLOW / 10);
  localparam logic [3:0] YL_ONES = 4'(YELLOW % 10);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {ST_MG, ST_MY, ST_SG, ST_SY, ST_EM} state_t;

  state_t     r_state;
  logic [2:0] r_main;
  logic [2:0] r_side;
  logic [3:0] r_tens;
  logic [3:0] r_ones;

  logic       r_cou_s1, r_cou_s2, r_cou_s3;
  logic       r_sh_s1, r_sh_s2;
  logic [1:0] r_fill;
  logic       r_cou_armed;
  logic       r_tick;

  // Arming waits until the synchroniser holds a real sample, so a COU_CLK already high at release is not an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cou_s1    <= 1'b0;
      r_cou_s2    <= 1'b0;
      r_cou_s3    <= 1'b0;
      r_sh_s1     <= 1'b0;
      r_sh_s2     <= 1'b0;
      r_fill      <= 2'b00;
      r_cou_armed <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_cou_s1    <= COU_CLK;
      r_cou_s2    <= r_cou_s1;
      r_cou_s3    <= r_cou_s2;
      r_sh_s1     <= SH_CLK;
      r_sh_s2     <= r_sh_s1;
      r_fill      <= {r_fill[0], 1'b1};
      r_cou_armed <= r_cou_armed | (r_fill[1] & ~r_cou_s2);
      r_tick      <= r_cou_s2 & ~r_cou_s3 & r_cou_armed;
    end
  end

`ifdef TRAFFIC_EMERGENCY_EN
  logic r_em_s1, r_em_s2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_em_s1 <= 1'b0;
      r_em_s2 <= 1'b0;
    end else begin
      r_em_s1 <= EMERG;
      r_em_s2 <= r_em_s1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{EMERG, r_sh_s2};
`endif

  // Phase FSM; lamps and count are registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_MG;
      r_main  <= LAMP_GRN;
      r_side  <= LAMP_RED;
      r_tens  <= GM_TENS;
      r_ones  <= GM_ONES;
    end else begin
`ifdef TRAFFIC_EMERGENCY_EN
      if (r_em_s2) begin
        r_state <= ST_EM;
        r_main  <= {1'b0, r_sh_s2, 1'b0};
        r_side  <= {1'b0, r_sh_s2, 1'b0};
        r_tens  <= 4'd0;
        r_ones  <= 4'd0;
      end else if (r_state == ST_EM) begin
        r_state <= ST_MG;
        r_main  <= LAMP_GRN;
        r_side  <= LAMP_RED;
        r_tens  <= GM_TENS;
        r_ones  <= GM_ONES;
      end else
`endif
      if (r_tick) begin
        if (r_tens == 4'd0 && r_ones == 4'd1) begin
          case (r_state)
            ST_MG: begin
              r_state <= ST_MY;
              r_main  <= LAMP_YEL;
              r_side  <= LAMP_RED;
              r_tens  <= YL_TENS;
              r_ones  <= YL_ONES;
            end
            ST_MY: begin
              r_state <= ST_SG;
              r_main  <= LAMP_RED;
              r_side  <= LAMP_GRN;
              r_tens  <= GS_TENS;
              r_ones  <= GS_ONES;
            end
            ST_SG: begin
              r_state <= ST_SY;
              r_main  <= LAMP_RED;
              r_side  <= LAMP_YEL;
              r_tens  <= YL_TENS;
              r_ones  <= YL_ONES;
            end
            default: begin
              r_state <= ST_MG;
              r_main  <= LAMP_GRN;
              r_side  <= LAMP_RED;
              r_tens  <= GM_TENS;
              r_ones  <= GM_ONES;
            end
          endcase
        end else if (r_ones == 4'd0) begin
          r_ones <= 4'd9;
          r_tens <= r_tens - 4'd1;
        end else begin
          r_ones <= r_ones - 4'd1;
        end
      end
    end
  end

  assign MAIN_LIGHT = r_main;
  assign SIDE_LIGHT = r_side;
  assign COUNT_TENS = r_tens;
  assign COUNT_ONES = r_ones;
  assign SEC_TICK   = r_tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with default timing 40/5/20/5.
// With TRAFFIC_EMERGENCY_EN undefined EMERG is held high throughout; defined, the EM entry/exit is exercised.
module tb_traffic_phase_ctrl;

  logic       CLK, RST_N, COU_CLK, SH_CLK, EMERG;
  logic [2:0] MAIN_LIGHT, SIDE_LIGHT;
  logic [3:0] COUNT_TENS, COUNT_ONES;
  logic       SEC_TICK;

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;
  int base;

  traffic_phase_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .COU_CLK    (COU_CLK),
    .SH_CLK     (SH_CLK),
    .EMERG      (EMERG),
    .MAIN_LIGHT (MAIN_LIGHT),
    .SIDE_LIGHT (SIDE_LIGHT),
    .COUNT_TENS (COUNT_TENS),
    .COUNT_ONES (COUNT_ONES),
    .SEC_TICK   (SEC_TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (SEC_TICK) n_ticks++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt();
    return {COUNT_TENS, COUNT_ONES};
  endfunction

  task automatic sec_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) COU_CLK = 1'b1;
      repeat (4) @(negedge CLK);
      COU_CLK = 1'b0;
      repeat (4) @(negedge CLK);
    end
  endtask

  initial begin
    RST_N   = 1'b0;
    COU_CLK = 1'b1;
    SH_CLK  = 1'b0;
`ifdef TRAFFIC_EMERGENCY_EN
    EMERG   = 1'b0;
`else
    EMERG   = 1'b1;
`endif
    repeat (3) @(negedge CLK);
    check("rst_main", 32'(MAIN_LIGHT), 32'h1);
    check("rst_side", 32'(SIDE_LIGHT), 32'h4);
    check("rst_cnt",  32'(cnt()), 32'h40);
    check("rst_tick", 32'(SEC_TICK), 32'h0);

    // Release with COU_CLK already high: no tick until a fresh rise.
    base = n_ticks;
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("no_spur_tick", 32'(n_ticks - base), 32'h0);
    check("no_spur_cnt",  32'(cnt()), 32'h40);
    COU_CLK = 1'b0;
    repeat (4) @(negedge CLK);

    // Single rise: tick on the 3rd CLK edge, one cycle wide.
    base = n_ticks;
    @(negedge CLK) COU_CLK = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    check("tick_edge2", 32'(SEC_TICK), 32'h0);
    @(posedge CLK); #1;
    check("tick_edge3", 32'(SEC_TICK), 32'h1);
    @(posedge CLK); #1;
    check("tick_edge4", 32'(SEC_TICK), 32'h0);
    check("cnt_39", 32'(cnt()), 32'h39);
    repeat (2) @(negedge CLK);
    COU_CLK = 1'b0;
    repeat (4) @(negedge CLK);
    check("tick_once", 32'(n_ticks - base), 32'h1);

    base = n_ticks;
    for (int i = 0; i < 10; i++) begin
      SH_CLK = ~SH_CLK;
      repeat (3) @(negedge CLK);
    end
    check("sh_no_tick", 32'(n_ticks - base), 32'h0);
    check("sh_cnt", 32'(cnt()), 32'h39);

    // Full cycle: MG 40, MY 5, SG 20, SY 5.
    sec_pulses(38);
    check("mg_01_cnt",  32'(cnt()), 32'h01);
    check("mg_01_main", 32'(MAIN_LIGHT), 32'h1);
    check("mg_01_side", 32'(SIDE_LIGHT), 32'h4);
    sec_pulses(1);
    check("my_main", 32'(MAIN_LIGHT), 32'h2);
    check("my_side", 32'(SIDE_LIGHT), 32'h4);
    check("my_cnt",  32'(cnt()), 32'h05);
    sec_pulses(4);
    check("my_01_cnt",  32'(cnt()), 32'h01);
    check("my_01_main", 32'(MAIN_LIGHT), 32'h2);
    sec_pulses(1);
    check("sg_main", 32'(MAIN_LIGHT), 32'h4);
    check("sg_side", 32'(SIDE_LIGHT), 32'h1);
    check("sg_cnt",  32'(cnt()), 32'h20);
    sec_pulses(10);
    check("sg_10_cnt", 32'(cnt()), 32'h10);
    sec_pulses(1);
    check("sg_09_cnt", 32'(cnt()), 32'h09);
    sec_pulses(8);
    check("sg_01_cnt", 32'(cnt()), 32'h01);
    sec_pulses(1);
    check("sy_main", 32'(MAIN_LIGHT), 32'h4);
    check("sy_side", 32'(SIDE_LIGHT), 32'h2);
    check("sy_cnt",  32'(cnt()), 32'h05);
    sec_pulses(4);
    check("sy_01_cnt", 32'(cnt()), 32'h01);
    sec_pulses(1);
    check("mg2_main", 32'(MAIN_LIGHT), 32'h1);
    check("mg2_side", 32'(SIDE_LIGHT), 32'h4);
    check("mg2_cnt",  32'(cnt()), 32'h40);

    // Asynchronous reset in SG at count 07.
    sec_pulses(58);
    check("sg07_main", 32'(MAIN_LIGHT), 32'h4);
    check("sg07_cnt",  32'(cnt()), 32'h07);
    @(negedge CLK) RST_N = 1'b0;
    #2;
    check("arst_main", 32'(MAIN_LIGHT), 32'h1);
    check("arst_side", 32'(SIDE_LIGHT), 32'h4);
    check("arst_cnt",  32'(cnt()), 32'h40);
    check("arst_tick", 32'(SEC_TICK), 32'h0);
    @(negedge CLK) RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    check("post_rst_cnt", 32'(cnt()), 32'h40);
    sec_pulses(1);
    check("post_rst_39", 32'(cnt()), 32'h39);

`ifdef TRAFFIC_EMERGENCY_EN
    // EMERG raised with a tick while MY shows 01.
    sec_pulses(43);
    check("em_pre_main", 32'(MAIN_LIGHT), 32'h2);
    check("em_pre_cnt",  32'(cnt()), 32'h01);
    @(negedge CLK);
    EMERG   = 1'b1;
    COU_CLK = 1'b1;
    repeat (4) @(negedge CLK);
    COU_CLK = 1'b0;
    check("em_cnt",       32'(cnt()), 32'h00);
    check("em_main_sh0",  32'(MAIN_LIGHT), 32'h0);
    check("em_side_sh0",  32'(SIDE_LIGHT), 32'h0);
    SH_CLK = 1'b1;
    repeat (4) @(negedge CLK);
    check("em_main_sh1",  32'(MAIN_LIGHT), 32'h2);
    check("em_side_sh1",  32'(SIDE_LIGHT), 32'h2);
    SH_CLK = 1'b0;
    repeat (4) @(negedge CLK);
    check("em_main_sh0b", 32'(MAIN_LIGHT), 32'h0);
    EMERG = 1'b0;
    repeat (4) @(negedge CLK);
    check("em_exit_main", 32'(MAIN_LIGHT), 32'h1);
    check("em_exit_side", 32'(SIDE_LIGHT), 32'h4);
    check("em_exit_cnt",  32'(cnt()), 32'h40);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
